// File: rtl/sequenciador_exibicao.sv
// rtl/sequenciador_exibicao.sv - plays the stored ROM sequence on the LEDs before each round
// Optional abort input/flag enabled by defining EXIBE_ABORTA_EN.
module sequenciador_exibicao #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int T_ACESO   = 1000,
  parameter int T_APAGADO = 500
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              iniciar_i,
  input  logic [ADDR_W-1:0] rodada_i,
  input  logic [DATA_W-1:0] dado_mem_i,
`ifdef EXIBE_ABORTA_EN
  input  logic              abortar_i,
  output logic              abortado_o,
`endif
  output logic [ADDR_W-1:0] endereco_o,
  output logic [DATA_W-1:0] leds_o,
  output logic              ocupado_o,
  output logic              pronto_o,
  output logic [3:0]        db_estado_o
);

  localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
  localparam int TMR_W = $clog2(T_MAX) + 1;
  localparam logic [TMR_W-1:0] FIM_ACESO   = TMR_W'(T_ACESO - 1);
  localparam logic [TMR_W-1:0] FIM_APAGADO = TMR_W'(T_APAGADO - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] ultimo_q, ultimo_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              aborta;

`ifdef EXIBE_ABORTA_EN
  logic abortado_q, abortado_d;
  assign aborta = abortar_i;
`else
  assign aborta = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      ultimo_q   <= '0;
      timer_q    <= '0;
`ifdef EXIBE_ABORTA_EN
      abortado_q <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      ultimo_q   <= ultimo_d;
      timer_q    <= timer_d;
`ifdef EXIBE_ABORTA_EN
      abortado_q <= abortado_d;
`endif
    end
  end

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    ultimo_d   = ultimo_q;
    timer_d    = timer_q;
`ifdef EXIBE_ABORTA_EN
    abortado_d = 1'b0;
`endif
    case (estado_q)
      OCIOSO: begin
        if (iniciar_i) begin
          ultimo_d   = rodada_i;
          endereco_d = '0;
          timer_d    = '0;
          estado_d   = CARREGA;
        end
      end
      CARREGA: begin
        timer_d  = '0;
        estado_d = ACESO;
      end
      ACESO: begin
        if (timer_q == FIM_ACESO) begin
          timer_d  = '0;
          estado_d = APAGADO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGADO: begin
        if (timer_q == FIM_APAGADO) begin
          timer_d  = '0;
          estado_d = (endereco_q == ultimo_q) ? FIM : PROXIMO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PROXIMO: begin
        endereco_d = endereco_q + 1'b1;
        estado_d   = CARREGA;
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // Abort wins over any normal step, but only while actively playing back.
    if (aborta && (estado_q == CARREGA || estado_q == ACESO ||
                   estado_q == APAGADO || estado_q == PROXIMO)) begin
      estado_d   = FIM;
      endereco_d = endereco_q;
      timer_d    = '0;
`ifdef EXIBE_ABORTA_EN
      abortado_d = 1'b1;
`endif
    end
  end

  always_comb begin
    leds_o      = '0;
    ocupado_o   = 1'b1;
    pronto_o    = 1'b0;
    db_estado_o = 4'h0;
    case (estado_q)
      OCIOSO: begin
        ocupado_o   = 1'b0;
        db_estado_o = 4'h0;
      end
      CARREGA: db_estado_o = 4'h1;
      ACESO: begin
        leds_o      = dado_mem_i;
        db_estado_o = 4'h2;
      end
      APAGADO: db_estado_o = 4'h3;
      PROXIMO: db_estado_o = 4'h4;
      FIM: begin
        pronto_o    = 1'b1;
        db_estado_o = 4'h5;
      end
      default: db_estado_o = 4'hF;
    endcase
  end

  assign endereco_o = endereco_q;

`ifdef EXIBE_ABORTA_EN
  assign abortado_o = abortado_q && (estado_q == FIM);
`endif

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// tb/tb_sequenciador_exibicao.sv - scoreboard bench for sequenciador_exibicao
module tb_sequenciador_exibicao;

  localparam int T_A = 4;
  localparam int T_P = 2;

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] endereco;
    logic       ocupado;
    logic       pronto;
    logic [3:0] estado;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [3:0] rodada = 4'd0;
  logic [3:0] dado_mem = 4'd0;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;
`ifdef EXIBE_ABORTA_EN
  logic       abortar = 1'b0;
  logic       abortado;
`endif

  logic [3:0] rom [16];
  exp_t       q [$];
  int         n_cmp = 0;
  int         n_err = 0;

  sequenciador_exibicao #(
    .ADDR_W(4), .DATA_W(4), .T_ACESO(T_A), .T_APAGADO(T_P)
  ) dut (
    .clock_i    (clk),
    .reset_i    (rst_n),
    .iniciar_i  (iniciar),
    .rodada_i   (rodada),
    .dado_mem_i (dado_mem),
`ifdef EXIBE_ABORTA_EN
    .abortar_i  (abortar),
    .abortado_o (abortado),
`endif
    .endereco_o (endereco),
    .leds_o     (leds),
    .ocupado_o  (ocupado),
    .pronto_o   (pronto),
    .db_estado_o(db_estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dado_mem <= rom[endereco];

  function automatic void push_e(input logic [3:0] l, input logic [3:0] a,
                                 input logic oc, input logic pr, input logic [3:0] st);
    exp_t e;
    e.leds = l; e.endereco = a; e.ocupado = oc; e.pronto = pr; e.estado = st;
    q.push_back(e);
  endfunction

  task automatic push_play(input int rod);
    for (int a = 0; a <= rod; a++) begin
      push_e(4'h0, 4'(a), 1'b1, 1'b0, 4'h1);
      for (int k = 0; k < T_A; k++) push_e(rom[a], 4'(a), 1'b1, 1'b0, 4'h2);
      for (int k = 0; k < T_P; k++) push_e(4'h0, 4'(a), 1'b1, 1'b0, 4'h3);
      if (a < rod) push_e(4'h0, 4'(a), 1'b1, 1'b0, 4'h4);
    end
    push_e(4'h0, 4'(rod), 1'b1, 1'b1, 4'h5);
  endtask

  task automatic run_trace(input string nome, input int n, input int drop_at,
                           input int chg_at, input logic [3:0] novo);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = q.pop_front();
      n_cmp++;
      if ({leds, endereco, ocupado, pronto, db_estado} !== e) begin
        n_err++;
        $display("FAIL %s[%0d]: got leds=%h end=%h oc=%b pr=%b st=%h, want leds=%h end=%h oc=%b pr=%b st=%h",
                 nome, i, leds, endereco, ocupado, pronto, db_estado,
                 e.leds, e.endereco, e.ocupado, e.pronto, e.estado);
      end
      if (i == drop_at) iniciar = 1'b0;
      if (i == chg_at) rodada = novo;
    end
  endtask

  task automatic start(input logic [3:0] r, input bit hold);
    @(negedge clk);
    rodada  = r;
    iniciar = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) iniciar = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) push_e(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    run_trace("reset_idle", 5, -1, -1, 4'h0);
  endtask

  task automatic test_single;
    rom[0] = 4'h1;
    push_play(0);
    push_e(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    push_e(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    start(4'd0, 1'b0);
    run_trace("single", q.size(), -1, -1, 4'h0);
  endtask

  task automatic test_three;
    rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h4;
    push_play(2);
    push_e(4'h0, 4'h2, 1'b0, 1'b0, 4'h0);
    push_e(4'h0, 4'h2, 1'b0, 1'b0, 4'h0);
    start(4'd2, 1'b0);
    run_trace("three", q.size(), -1, -1, 4'h0);
  endtask

  task automatic test_back_to_back;
    int n1;
    rom[3] = 4'h8; rom[4] = 4'h3; rom[5] = 4'hA;
    push_play(1);
    n1 = q.size();
    push_e(4'h0, 4'h1, 1'b0, 1'b0, 4'h0);
    push_play(5);
    push_e(4'h0, 4'h5, 1'b0, 1'b0, 4'h0);
    start(4'd1, 1'b1);
    run_trace("hold_restart", q.size(), n1 + 1, 3, 4'd5);
  endtask

  task automatic test_reset_mid;
    push_play(3);
    start(4'd3, 1'b0);
    run_trace("pre_reset", 10, -1, -1, 4'h0);
    q.delete();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({leds, endereco, ocupado, pronto, db_estado} !== 15'd0) begin
      n_err++;
      $display("FAIL async_reset: got leds=%h end=%h oc=%b pr=%b st=%h, want all 0",
               leds, endereco, ocupado, pronto, db_estado);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (pronto !== 1'b0 || db_estado !== 4'h0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got pr=%b st=%h, want pr=0 st=0", i, pronto, db_estado);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_e(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    run_trace("post_reset", 4, -1, -1, 4'h0);
  endtask

`ifdef EXIBE_ABORTA_EN
  task automatic test_abort;
    push_play(3);
    start(4'd3, 1'b0);
    run_trace("pre_abort", 10, -1, -1, 4'h0);
    q.delete();
    abortar = 1'b1;
    @(negedge clk);
    abortar = 1'b0;
    n_cmp++;
    if ({db_estado, pronto, abortado, leds, endereco} !== {4'h5, 1'b1, 1'b1, 4'h0, 4'h1}) begin
      n_err++;
      $display("FAIL abort_fim: got st=%h pr=%b ab=%b leds=%h end=%h, want st=5 pr=1 ab=1 leds=0 end=1",
               db_estado, pronto, abortado, leds, endereco);
    end
    @(negedge clk);
    n_cmp++;
    if ({db_estado, pronto, abortado} !== {4'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abort_after: got st=%h pr=%b ab=%b, want st=0 pr=0 ab=0",
               db_estado, pronto, abortado);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    test_reset();
    test_single();
    test_three();
    test_back_to_back();
    test_reset_mid();
`ifdef EXIBE_ABORTA_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
